// File: rtl/intensity_select_ctrl_pkg.sv
// Shared definitions for the intensity select controller and the downstream
// 3-way mux: select codes and the controller's FSM state encoding.
package intensity_select_ctrl_pkg;

  // Mux codes: 00 forces full white, 01 forces black, 10 passes the pixel.
  typedef enum logic [1:0] {
    SEL_WHITE = 2'b00,
    SEL_BLACK = 2'b01,
    SEL_PASS  = 2'b10
  } sel_t;

  // Controller FSM: waiting for a frame, collecting pixels, one-cycle verdict.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

endpackage

// File: rtl/intensity_select_ctrl_if.sv
// Pixel stream in, registered pixel plus mux select out.
//
// Handshake: pix_valid qualifies pix_in and sof in the same cycle; there is
// no ready, so the sink must take every valid pixel. pix_out_valid likewise
// qualifies pix_out for exactly one cycle. count_valid is a one-cycle strobe
// marking the cycle in which mass_count and select carry a fresh verdict.
interface intensity_select_ctrl_if #(
  parameter int FRAME_PIXELS = 16
);
  import intensity_select_ctrl_pkg::*;

  localparam int CW = $clog2(FRAME_PIXELS + 1);

  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          sof;
  logic [7:0]    pix_out;
  logic          pix_out_valid;
  logic [1:0]    select;
  logic [CW-1:0] mass_count;
  logic          count_valid;
  state_t        state;  // FSM state, observable for checkers

  modport master (
    output pix_in, pix_valid, sof,
    input  pix_out, pix_out_valid, select, mass_count, count_valid, state
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output pix_out, pix_out_valid, select, mass_count, count_valid, state
  );

endinterface

// File: rtl/intensity_select_ctrl.sv
// Counts bright pixels per frame and, once a frame completes, chooses whether
// the next frame is forced white, forced black or passed through.
module intensity_select_ctrl
  import intensity_select_ctrl_pkg::*;
#(
  parameter int FRAME_PIXELS = 16,
  parameter int THRESH       = 128,
  parameter int HI_COUNT     = 12,
  parameter int LO_COUNT     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  intensity_select_ctrl_if.slave   bus
);

  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_PIXELS);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] pix_cnt;
  logic [CW-1:0] bright_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] acc_nxt;
  logic [CW-1:0] mass_q;
  logic [7:0]    pix_q;
  logic          pix_valid_q;
  logic          count_valid_q;
  sel_t          sel_q;
  sel_t          decide_sel;
  logic          accept;
  logic          bright;
  logic          frame_done;
  logic          decide_now;

  // Acceptance and next counter values; an sof pixel always restarts at 1.
  always_comb begin
    accept     = bus.pix_valid && (bus.sof || (state == ACCUM));
    bright     = ({1'b0, bus.pix_in} >= 9'(THRESH));
    cnt_nxt    = bus.sof ? CW'(1) : pix_cnt + CW'(1);
    acc_nxt    = bus.sof ? CW'(bright) : bright_cnt + CW'(bright);
    frame_done = accept && (cnt_nxt == FRAME_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: any accepted pixel may open or close a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = frame_done ? DECIDE : ACCUM;
      ACCUM:   if (frame_done) state_nxt = DECIDE;
      DECIDE:  if (accept) state_nxt = frame_done ? DECIDE : ACCUM;
               else        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: verdict for the frame just completed.
  always_comb begin
    decide_now = (state == DECIDE);
    if (int'(bright_cnt) >= HI_COUNT)      decide_sel = SEL_WHITE;
    else if (int'(bright_cnt) <= LO_COUNT) decide_sel = SEL_BLACK;
    else                                   decide_sel = SEL_PASS;
  end

  // Datapath: counters, pixel pipeline stage and the verdict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt       <= '0;
      bright_cnt    <= '0;
      pix_q         <= '0;
      pix_valid_q   <= 1'b0;
      count_valid_q <= 1'b0;
      mass_q        <= '0;
      sel_q         <= SEL_PASS;
    end else begin
      pix_valid_q   <= accept;
      count_valid_q <= decide_now;
      if (accept) begin
        pix_cnt    <= cnt_nxt;
        bright_cnt <= acc_nxt;
        pix_q      <= bus.pix_in;
      end
      if (decide_now) begin
        mass_q <= bright_cnt;
        sel_q  <= decide_sel;
      end
    end
  end

  assign bus.pix_out       = pix_q;
  assign bus.pix_out_valid = pix_valid_q;
  assign bus.count_valid   = count_valid_q;
  assign bus.mass_count    = mass_q;
  assign bus.select        = sel_q;
  assign bus.state         = state;

endmodule

// File: doc/intensity_select_ctrl.md
INTENSITY_SELECT_CTRL -- requirements
Module: intensity_select_ctrl

Interface
REQ-001 Parameter FRAME_PIXELS, default 16: pixels per frame.
REQ-002 Parameter THRESH, default 128: a pixel is bright when its value is at least THRESH (unsigned compare).
REQ-003 Parameter HI_COUNT, default 12: bright-count limit at or above which the next frame is forced white.
REQ-004 Parameter LO_COUNT, default 4: bright-count limit at or below which the next frame is forced black; LO_COUNT < HI_COUNT is required.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pix_in  in  8  input pixel intensity.
REQ-008 pix_valid  in  1  pix_in valid this cycle; no back-pressure.
REQ-009 sof  in  1  start of frame, qualified by pix_valid, marks first pixel.
REQ-010 pix_out  out  8  registered pixel, aligned with select, for downstream 3-way mux.
REQ-011 pix_out_valid  out  1  pix_out valid.
REQ-012 select  out  2  mux code: 00 force 255, 01 force 0, 10 pass pixel.
REQ-013 mass_count  out  CW  bright-pixel count of last completed frame, CW = clog2(FRAME_PIXELS+1).
REQ-014 count_valid  out  1  one-cycle pulse when mass_count/select update.

Function
REQ-015 FSM states IDLE, ACCUM, DECIDE; pixels accepted only when pix_valid=1 and (sof=1 in any state, or state=ACCUM).
REQ-016 IDLE: accepted sof pixel -> ACCUM, pixel counter=1, bright accumulator=(pix_in>=THRESH).
REQ-017 ACCUM: each accepted non-sof pixel increments pixel counter and adds (pix_in>=THRESH) to accumulator.
REQ-018 ACCUM: when the accepted pixel is number FRAME_PIXELS -> DECIDE next cycle.
REQ-019 DECIDE lasts exactly one cycle: mass_count<=accumulator, count_valid=1, select<=00 if accumulator>=HI_COUNT, 01 if <=LO_COUNT, else 10.
REQ-020 DECIDE exit: ACCUM (new frame, as REQ-016) if sof pixel accepted that cycle, else IDLE.
REQ-021 sof accepted while in ACCUM restarts the frame per REQ-016; no decision, no count_valid, select and mass_count unchanged.
REQ-022 Valid non-sof pixels in IDLE or DECIDE are dropped: not counted, pix_out_valid=0.
REQ-023 Accepted pixel appears on pix_out with pix_out_valid=1 exactly one cycle later; pix_out holds otherwise.
REQ-024 select changes only at the DECIDE edge, so the last pixel of frame N carries the old code and first pixel of frame N+1 (sof in DECIDE) carries the new code.
REQ-025 Accumulator and pixel counter never wrap: width CW, max value FRAME_PIXELS.
REQ-026 Consecutive frames with no gap (sof on cycle after last pixel) lose no pixels.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, counters 0, pix_out 0, pix_out_valid 0, select 10, mass_count 0, count_valid 0.
REQ-028 Reset mid-frame discards the partial frame; after release, first accepted sof starts a fresh frame.

Structure
REQ-029 Shared package holds select codes (SEL_WHITE=00, SEL_BLACK=01, SEL_PASS=10) and FSM state enum; the downstream mux imports same codes.
REQ-030 Single module, no sub-modules; threshold compare and decision logic inline.

Verification (FRAME_PIXELS=16, THRESH=128, HI=12, LO=4)
REQ-031 Frame of 16 pixels all 200 -> count_valid pulse, mass_count=16, select=00 from next frame's first pixel.
REQ-032 Frame of 16 pixels all 10 -> mass_count=0, select=01; frame with 8 pixels 128 and 8 pixels 127 -> mass_count=8, select=10.
REQ-033 Boundaries: 12 bright -> select=00; 11 -> 10; 4 -> 01; 5 -> 10.
REQ-034 sof re-asserted at pixel 9 of a frame, then 16 pixels all 255 -> single count_valid, mass_count=16.
REQ-035 Back-to-back frames with sof in DECIDE cycle -> 32 pix_out_valid pulses, last pixel of frame 1 with old select, first of frame 2 with new.
REQ-036 rst_n low at pixel 7 -> all outputs at reset values immediately; no count_valid until a full 16-pixel frame after release.
